// File: rtl/tone_detect_pkg.sv
// Shared types and helpers for the tone detector: FSM encoding and timing derivation.
package tone_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 24_000_000;
  localparam int unsigned CNT_W          = 24;

  // Nominal half-period of a tone at freq, in clock cycles.
  function automatic int unsigned half_cycles(input int unsigned clk_hz, input int unsigned freq);
    return clk_hz / (2 * freq);
  endfunction

endpackage

// File: rtl/tone_detect_sync_edge.sv
// Two-flop synchroniser plus an edge flop; reusable for any asynchronous level input.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_edge  = r_s2 ^ r_s3;

endmodule

// File: rtl/tone_detect.sv
// Measures half-periods of an asynchronous square wave and asserts tone while it
// stays locked to FREQ within +/-TOL cycles.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no reference edge yet; next edge starts a measurement
// ST_ACQUIRE | counting consecutive in-window half-periods toward LOCK_N
// ST_LOCKED  | tone present; any bad half-period or timeout drops lock
module tone_detect
  import tone_detect_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ   = 1000,
  parameter int unsigned TOL    = 1500,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             clk_24,
  input  logic             rst,
  input  logic             audio_in,
  output logic             tone,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  localparam int unsigned      HALF     = half_cycles(CLK_HZ, FREQ);
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(HALF - TOL);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(HALF + TOL);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gcnt;

  logic             w_edge;
  logic             w_sync_unused;
  logic [CNT_W-1:0] w_n;
  logic             w_in_win;
  logic             w_good;
  logic             w_bad;
  logic             w_timeout;

  sync_edge u_sync_edge (
    .i_clk   (clk_24),
    .i_rst   (rst),
    .i_async (audio_in),
    .o_level (w_sync_unused),
    .o_edge  (w_edge)
  );

  // Saturating cnt+1: doubles as the next counter value and the measured half-period.
  assign w_n       = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_in_win  = (w_n >= WIN_LO) && (w_n <= WIN_HI);
  assign w_good    = w_edge && w_in_win;
  assign w_bad     = w_edge && !w_in_win;
  assign w_timeout = !w_edge && (r_cnt == WIN_HI);

  always_ff @(posedge clk_24) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_gcnt       <= '0;
      tone         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      r_cnt        <= w_edge ? '0 : w_n;
      period_valid <= 1'b0;

      // The first edge after IDLE is only a reference and yields no measurement.
      if (w_edge && (r_state != ST_IDLE)) begin
        period       <= w_n;
        period_valid <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_ACQUIRE;
            r_gcnt  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (w_good) begin
            r_gcnt <= r_gcnt + 4'd1;
            if ((r_gcnt + 4'd1) == LOCK_TGT) begin
              r_state <= ST_LOCKED;
              tone    <= 1'b1;
            end
          end else if (w_bad) begin
            r_gcnt <= '0;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_gcnt  <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            r_state <= ST_ACQUIRE;
            r_gcnt  <= '0;
            tone    <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_gcnt  <= '0;
            tone    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gcnt  <= '0;
          tone    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detect.sv
// Directed bench for tone_detect, scaled to HALF=100 / TOL=12 so every scenario fits a short run.
module tb_tone_detect;

  localparam int CLK_HZ = 200_000;
  localparam int FREQ   = 1000;
  localparam int TOL    = 12;
  localparam int LOCK_N = 4;
  localparam int HALF   = 100;

  logic        clk_24   = 1'b0;
  logic        rst      = 1'b1;
  logic        audio_in = 1'b0;
  logic        tone;
  logic [23:0] period;
  logic        period_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  int          cyc         = 0;
  int          pv_cnt      = 0;
  int          last_pv_cyc = -1;
  logic [23:0] last_period = '0;
  int          rise_cnt    = 0;
  int          rise_cyc    = -1;
  int          fall_cyc    = -1;
  logic        tone_q      = 1'b0;

  tone_detect #(
    .CLK_HZ (CLK_HZ),
    .FREQ   (FREQ),
    .TOL    (TOL),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk_24       (clk_24),
    .rst          (rst),
    .audio_in     (audio_in),
    .tone         (tone),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 clk_24 = ~clk_24;

  always @(posedge clk_24) cyc <= cyc + 1;

  // Observation only: timestamps (in posedge counts) of pulses and tone transitions.
  always @(negedge clk_24) begin
    tone_q <= tone;
    if (period_valid === 1'b1) begin
      pv_cnt      <= pv_cnt + 1;
      last_pv_cyc <= cyc;
      last_period <= period;
    end
    if (tone === 1'b1 && tone_q !== 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (tone === 1'b0 && tone_q === 1'b1) fall_cyc <= cyc;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_24);
    #1;
  endtask

  // n toggles of audio_in, h cycles apart; returns h cycles after the last toggle.
  task automatic wave(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      audio_in = ~audio_in;
      step(h);
    end
  endtask

  task automatic do_reset();
    audio_in = 1'b0;
    rst      = 1'b1;
    step(3);
    rst = 1'b0;
    step(5);
  endtask

  task automatic test_reset();
    int r0;
    audio_in = 1'b0;
    rst      = 1'b1;
    step(3);
    tests_run++;
    if (tone !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tone got=%b exp=0", tone);
    end
    tests_run++;
    if (period !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_period got=%0d exp=0", period);
    end
    tests_run++;
    if (period_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pv got=%b exp=0", period_valid);
    end
    rst = 1'b0;
    r0  = rise_cnt;
    step(200);
    tests_run++;
    if (rise_cnt != r0 || pv_cnt != 0) begin
      tests_failed++;
      $display("FAIL idle_quiet rises=%0d pvs=%0d exp=0,0", rise_cnt - r0, pv_cnt);
    end
  endtask

  task automatic test_ideal();
    int j0, p0;
    do_reset();
    j0 = cyc;
    p0 = pv_cnt;
    wave(HALF, 2);
    tests_run++;
    if (pv_cnt - p0 != 1 || last_pv_cyc != j0 + 103 || last_period !== 24'd100) begin
      tests_failed++;
      $display("FAIL ideal_first_pv cnt=%0d cyc=%0d per=%0d exp=1,%0d,100",
               pv_cnt - p0, last_pv_cyc - j0, last_period, 103);
    end
    tests_run++;
    if (tone !== 1'b0) begin
      tests_failed++;
      $display("FAIL ideal_early_tone got=%b exp=0", tone);
    end
    wave(HALF, 4);
    tests_run++;
    if (rise_cyc != j0 + 4 * HALF + 3 || tone !== 1'b1) begin
      tests_failed++;
      $display("FAIL ideal_lock rise_at=%0d tone=%b exp=%0d,1", rise_cyc - j0, tone, 4 * HALF + 3);
    end
    tests_run++;
    if (pv_cnt - p0 != 5 || last_period !== 24'd100) begin
      tests_failed++;
      $display("FAIL ideal_pv_count cnt=%0d per=%0d exp=5,100", pv_cnt - p0, last_period);
    end
  endtask

  task automatic test_key_up();
    int j0;
    do_reset();
    j0 = cyc;
    wave(HALF, 6);
    step(30);
    // last edge seen at j0+503; timeout when cnt reaches HALF+TOL, registered one cycle later
    tests_run++;
    if (fall_cyc != j0 + 503 + HALF + TOL + 1 || tone !== 1'b0) begin
      tests_failed++;
      $display("FAIL key_up_fall fall_at=%0d tone=%b exp=%0d,0", fall_cyc - j0, tone, 503 + HALF + TOL + 1);
    end
  endtask

  task automatic test_window();
    int h_good[2];
    int j0, p0, r0;
    h_good[0] = HALF - TOL;
    h_good[1] = HALF + TOL;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      j0 = cyc;
      wave(h_good[k], 6);
      tests_run++;
      if (tone !== 1'b1 || rise_cyc != j0 + 4 * h_good[k] + 3 || last_period !== 24'(h_good[k])) begin
        tests_failed++;
        $display("FAIL window_good h=%0d tone=%b rise_at=%0d per=%0d exp=1,%0d,%0d",
                 h_good[k], tone, rise_cyc - j0, last_period, 4 * h_good[k] + 3, h_good[k]);
      end
    end
    // just below the window: every edge measured and rejected
    do_reset();
    p0 = pv_cnt;
    r0 = rise_cnt;
    wave(HALF - TOL - 1, 8);
    tests_run++;
    if (tone !== 1'b0 || rise_cnt != r0 || pv_cnt - p0 != 7 || last_period !== 24'(HALF - TOL - 1)) begin
      tests_failed++;
      $display("FAIL window_short tone=%b rises=%0d pvs=%0d per=%0d exp=0,0,7,%0d",
               tone, rise_cnt - r0, pv_cnt - p0, last_period, HALF - TOL - 1);
    end
    // just above the window: never locks
    do_reset();
    r0 = rise_cnt;
    wave(HALF + TOL + 1, 8);
    tests_run++;
    if (tone !== 1'b0 || rise_cnt != r0) begin
      tests_failed++;
      $display("FAIL window_long tone=%b rises=%0d exp=0,0", tone, rise_cnt - r0);
    end
  endtask

  task automatic test_wrong_freq();
    int p0, r0;
    do_reset();
    p0 = pv_cnt;
    r0 = rise_cnt;
    // 800 Hz equivalent: each half-period times out first, so every edge is a fresh reference
    wave(HALF * 5 / 4, 12);
    tests_run++;
    if (tone !== 1'b0 || rise_cnt != r0 || pv_cnt != p0) begin
      tests_failed++;
      $display("FAIL wrong_freq tone=%b rises=%0d pvs=%0d exp=0,0,0", tone, rise_cnt - r0, pv_cnt - p0);
    end
  endtask

  task automatic test_glitch();
    int j0;
    do_reset();
    j0 = cyc;
    wave(HALF, 6);
    wave(50, 1);
    wave(10, 1);
    tests_run++;
    if (tone !== 1'b0 || fall_cyc != j0 + 653) begin
      tests_failed++;
      $display("FAIL glitch_fall tone=%b fall_at=%0d exp=0,653", tone, fall_cyc - j0);
    end
    tests_run++;
    if (last_pv_cyc != j0 + 653 || last_period !== 24'd50) begin
      tests_failed++;
      $display("FAIL glitch_period at=%0d per=%0d exp=653,50", last_pv_cyc - j0, last_period);
    end
    wave(40, 1);
    wave(HALF, 5);
    tests_run++;
    if (tone !== 1'b1 || rise_cyc != j0 + 1103) begin
      tests_failed++;
      $display("FAIL glitch_relock tone=%b rise_at=%0d exp=1,1103", tone, rise_cyc - j0);
    end
  endtask

  task automatic test_reset_locked();
    int k, p0;
    do_reset();
    wave(HALF, 6);
    tests_run++;
    if (tone !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_prelock tone=%b exp=1", tone);
    end
    rst = 1'b1;
    step(1);
    tests_run++;
    if (tone !== 1'b0 || period !== 24'd0 || period_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_locked tone=%b per=%0d pv=%b exp=0,0,0", tone, period, period_valid);
    end
    rst = 1'b0;
    k   = cyc;
    p0  = pv_cnt;
    wave(HALF, 6);
    tests_run++;
    if (tone !== 1'b1 || rise_cyc != k + 4 * HALF + 3 || pv_cnt - p0 != 5) begin
      tests_failed++;
      $display("FAIL rst_relock tone=%b rise_at=%0d pvs=%0d exp=1,%0d,5",
               tone, rise_cyc - k, pv_cnt - p0, 4 * HALF + 3);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_key_up();
    test_window();
    test_wrong_freq();
    test_glitch();
    test_reset_locked();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
